// File: rtl/osc_pkg.sv
// osc_pkg: shared waveform/FSM encodings and LFSR constants for the poly oscillator.
package osc_pkg;

    typedef enum logic [1:0] {
        WVF_SQUARE   = 2'd0,
        WVF_SAW      = 2'd1,
        WVF_TRIANGLE = 2'd2,
        WVF_NOISE    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/osc_wave_gen.sv
// osc_wave_gen: combinational waveform generator shared by all voices.
module osc_wave_gen
    import osc_pkg::*;
#(
    parameter int PHASE_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 12
) (
    input  logic [PHASE_WIDTH-1:0]  phase,
    input  wave_t                   sel,
    input  logic [OUTPUT_WIDTH-1:0] pw,
    input  logic [15:0]             lfsr,
    output logic [OUTPUT_WIDTH-1:0] sample
);

    logic [OUTPUT_WIDTH-1:0] t;
    logic [OUTPUT_WIDTH-1:0] u;
    // Low phase bits and low LFSR bits do not reach the output.
    logic [PHASE_WIDTH+15:0] unused_bits;

    assign unused_bits = {phase, lfsr};

    always_comb begin
        t = phase[PHASE_WIDTH-1 -: OUTPUT_WIDTH];
        u = phase[PHASE_WIDTH-2 -: OUTPUT_WIDTH];
        sample = sel == WVF_SAW      ? t :
                 sel == WVF_SQUARE   ? {OUTPUT_WIDTH{t < pw}} :
                 sel == WVF_TRIANGLE ? (phase[PHASE_WIDTH-1] ? ~u : u) :
                                       lfsr[15 -: OUTPUT_WIDTH];
    end

endmodule

// File: rtl/poly_oscillator.sv
// poly_oscillator: NUM_VOICES phase accumulators sharing one waveform generator,
// processed one voice per cycle after each sample strobe and mixed to mono.
module poly_oscillator
    import osc_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int PHASE_WIDTH  = 24,
    parameter int FREQ_BITS    = 16,
    parameter int OUTPUT_WIDTH = 12,
    localparam int VOICE_BITS  = $clog2(NUM_VOICES)
) (
    input  logic                    main_clk,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic                    cfg_we,
    input  logic [VOICE_BITS-1:0]   cfg_voice,
    input  logic [1:0]              cfg_sel,
    input  logic [FREQ_BITS-1:0]    cfg_freq,
    input  logic [OUTPUT_WIDTH-1:0] cfg_pw,
    input  logic                    cfg_gate,
    output logic [OUTPUT_WIDTH-1:0] mix_out,
    output logic                    mix_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ACC_WIDTH = OUTPUT_WIDTH + VOICE_BITS;
    localparam logic [OUTPUT_WIDTH-1:0] PW_RESET = OUTPUT_WIDTH'(1) << (OUTPUT_WIDTH - 1);

    logic [PHASE_WIDTH-1:0]  phase [NUM_VOICES];
    logic [FREQ_BITS-1:0]    freq  [NUM_VOICES];
    wave_t                   sel   [NUM_VOICES];
    logic [OUTPUT_WIDTH-1:0] pw    [NUM_VOICES];
    logic                    gate  [NUM_VOICES];

    state_t                  state;
    logic [VOICE_BITS-1:0]   idx;
    logic [ACC_WIDTH-1:0]    acc;
    logic [15:0]             lfsr;
    logic [OUTPUT_WIDTH-1:0] sample;

    osc_wave_gen #(
        .PHASE_WIDTH  (PHASE_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_wave_gen (
        .phase  (phase[idx]),
        .sel    (sel[idx]),
        .pw     (pw[idx]),
        .lfsr   (lfsr),
        .sample (sample)
    );

    // Config writes land at the edge, so a voice being processed this cycle still sees its old values.
    always_ff @(posedge main_clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq[i] <= '0;
                sel[i]  <= WVF_SQUARE;
                pw[i]   <= PW_RESET;
                gate[i] <= 1'b0;
            end
        end else if (cfg_we) begin
            freq[cfg_voice] <= cfg_freq;
            sel[cfg_voice]  <= wave_t'(cfg_sel);
            pw[cfg_voice]   <= cfg_pw;
            gate[cfg_voice] <= cfg_gate;
        end
    end

    always_ff @(posedge main_clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            lfsr      <= LFSR_SEED;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (sample_en && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (sample_en) begin
                    acc   <= '0;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // Ungated voices still advance so they stay phase-continuous.
                    phase[idx] <= phase[idx] + PHASE_WIDTH'(freq[idx]);
                    acc        <= acc + (gate[idx] ? ACC_WIDTH'(sample) : '0);
                    lfsr       <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
                    if (idx == VOICE_BITS'(NUM_VOICES - 1)) state <= DONE;
                    else idx <= idx + 1'b1;
                end
                DONE: begin
                    mix_out   <= acc[ACC_WIDTH-1 -: OUTPUT_WIDTH];
                    mix_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = state != IDLE;

endmodule

// File: doc/poly_oscillator.md
Name: poly_oscillator

Overview:
- Multi-voice successor to the single-voice oscillator.
- NUM_VOICES independent phase accumulators, each with its own frequency, waveform, pulse width and gate, share one waveform generator.
- One voice is processed per main_clk cycle after each sample strobe; the gated voices are summed and scaled into one mono mix sample.
- Sits between the control/register block, which drives the cfg_* port, and the downstream filter/DAC path, which consumes mix_out/mix_valid.

Parameters:
- NUM_VOICES, 4: voice count; power of two, >= 2.
- PHASE_WIDTH, 24: phase accumulator width per voice.
- FREQ_BITS, 16: per-voice phase increment width; FREQ_BITS <= PHASE_WIDTH.
- OUTPUT_WIDTH, 12: sample width; OUTPUT_WIDTH <= 16 and OUTPUT_WIDTH <= PHASE_WIDTH-1.
- VOICE_BITS (localparam), $clog2(NUM_VOICES): voice index width.

Ports:
- main_clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge main_clk.
- sample_en  in  1  one-cycle sample strobe, synchronous to main_clk.
- cfg_we  in  1  write strobe for one voice's configuration.
- cfg_voice  in  VOICE_BITS  target voice index.
- cfg_sel  in  2  waveform: 0 square, 1 saw, 2 triangle, 3 noise.
- cfg_freq  in  FREQ_BITS  phase increment per sample.
- cfg_pw  in  OUTPUT_WIDTH  square pulse-width threshold.
- cfg_gate  in  1  voice contributes to the mix when 1.
- mix_out  out  OUTPUT_WIDTH  mixed sample, held between updates.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high in RUN and DONE.
- overrun  out  1  sticky: a sample_en arrived while busy.

Behaviour:
- Reset (reset==0 at a clock edge):
  - all phase accumulators = 0; freq, sel and gate = 0 for every voice; pw = 1<<(OUTPUT_WIDTH-1).
  - LFSR = 16'hACE1; state = IDLE.
  - mix_out = 0, mix_valid = 0, busy = 0, overrun = 0.
  - A reset during RUN/DONE aborts the sequence; no mix_valid is produced.
- FSM:
  - IDLE: on sample_en, clear the accumulator, idx = 0, go to RUN.
  - RUN: process voice idx. If idx == NUM_VOICES-1 go to DONE, else idx+1.
  - DONE: mix_out <= acc >> VOICE_BITS; mix_valid = 1 for exactly this cycle; go to IDLE.
- Latency: edge E samples sample_en. Voices are processed at edges E+1..E+NUM_VOICES. mix_out/mix_valid register at edge E+NUM_VOICES+1. Minimum strobe spacing is NUM_VOICES+2 cycles.
- Voice processing (RUN):
  - Sample is generated from the phase value before the increment.
  - Then phase <= phase + zero-extended freq, modulo 2^PHASE_WIDTH (natural wrap).
  - acc += gate ? sample : 0.
  - acc is OUTPUT_WIDTH+VOICE_BITS bits wide, so it never overflows.
- Phase advance ignores gate: ungated voices keep running so they stay phase-continuous.
- Waveforms, with t = phase[PHASE_WIDTH-1 -: OUTPUT_WIDTH] and u = phase[PHASE_WIDTH-2 -: OUTPUT_WIDTH]:
  - saw = t.
  - square = (t < pw) ? all-ones : 0.
  - triangle = phase MSB ? ~u : u.
  - noise = LFSR[15 -: OUTPUT_WIDTH].
- LFSR:
  - Fibonacci, taps 16,14,13,11; shift left; feedback into bit 0.
  - Advances once per RUN cycle, whatever each voice's sel.
  - Never reaches 0 from its seed.
- Config writes:
  - Accepted in any state and take effect at the clock edge.
  - A write to the voice being processed in the same cycle: that cycle uses the old values; the new values apply from the next sample.
  - Phase is not writable and is not reset by config writes.
- sample_en while busy: ignored, and overrun is set at that edge. overrun stays set until reset.
- sample_en in the DONE cycle also counts as busy and is ignored.

Decomposition:
- Package osc_pkg:
  - waveform select encodings (WVF_SQUARE=0, WVF_SAW=1, WVF_TRIANGLE=2, WVF_NOISE=3);
  - FSM state encoding (IDLE, RUN, DONE);
  - LFSR seed 16'hACE1 and tap constants.
- Sub-module osc_wave_gen: combinational. Inputs phase, sel, pw, lfsr; output sample. Parametrised by PHASE_WIDTH and OUTPUT_WIDTH.
- Top level holds the voice register arrays, FSM, accumulator and LFSR.

Test Plan:
All tests use the defaults: NUM_VOICES=4, PHASE_WIDTH=24, OUTPUT_WIDTH=12.
1. Reset:
   - Stimulus: hold reset=0 for 3 cycles, then release with no further activity.
   - Required: mix_out=0, mix_valid=0, busy=0, overrun=0; busy stays 0 until sample_en.
2. Saw, voice 0 only:
   - Stimulus: voice 0 set to sel=1, freq=0x10000, gate=1; other voices gate=0.
   - Required: successive mix_out = 0, 4, 8, 12…; mix_valid occurs exactly 5 edges after each sample_en.
3. Square, all voices:
   - Stimulus: all 4 voices set to sel=0, freq=0, pw=0x800, gate=1.
   - Required: mix_out=0xFFF.
   - Then set pw=0 on all voices: mix_out=0.
4. Triangle with wrap:
   - Stimulus: voice 0 set to sel=2, freq=0x400000 (24-bit increment; needs FREQ_BITS >= 23 for this test), gate=1.
   - Required over 5 samples: mix_out = 0x000, 0x200, 0x3FF, 0x1FF, 0x000 (phase wraps back to 0).
5. Overrun:
   - Stimulus: sample_en at cycle 0 and again at cycle 2.
   - Required: exactly one mix_valid (edge 5); overrun=1 from edge 2 and held until reset.
6. Collision and mid-run reset:
   - Stimulus: cfg write to voice 1 (freq=0x20000) in the same cycle voice 1 is processed.
   - Required: that sample's phase step uses the old freq; the next sample uses 0x20000.
   - Stimulus: reset=0 during RUN.
   - Required: no mix_valid; busy=0 on the next cycle.
